pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/adder_pkg.sv | 16 +
 rtl/fa_cell.sv | 13 +
 rtl/pipe_adder.sv | 107 ++++++++++
 tb/tb_pipe_adder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults and chunk derivation for pipe_adder
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Each stage resolves an equal slice of the operand; a zero stage count yields 0.
  function automatic int chunk_width(input int width, input int stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

  function automatic bit params_legal(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - one-bit full adder used to build each stage's ripple chain
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - carry-pipelined adder, one operand chunk per stage with valid/ready flow
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int MSB   = WIDTH - 1;
  localparam int LAST  = STAGES - 1;

  if (!params_legal(WIDTH, STAGES)) begin : g_param_check
    $error("pipe_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0 (WIDTH=%0d STAGES=%0d)",
           WIDTH, STAGES);
  end

  logic             w_en;
  logic             r_valid   [STAGES];
  logic [WIDTH-1:0] r_a       [STAGES];
  logic [WIDTH-1:0] r_b       [STAGES];
  logic [WIDTH-1:0] r_sum     [STAGES];
  logic             r_carry   [STAGES];
  logic             w_src_valid [STAGES];
  logic [WIDTH-1:0] w_src_a     [STAGES];
  logic [WIDTH-1:0] w_src_b     [STAGES];
  logic [WIDTH-1:0] w_src_sum   [STAGES];
  logic             w_src_carry [STAGES];
  logic [WIDTH-1:0] w_sum_next  [STAGES];
  logic             w_carry_next[STAGES];

  assign w_en     = !r_valid[LAST] || out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK:0]   w_c;
    logic [CHUNK-1:0] w_s;

    if (k == 0) begin : g_head
      assign w_src_valid[k] = in_valid;
      assign w_src_a[k]     = a;
      assign w_src_b[k]     = b;
      assign w_src_sum[k]   = '0;
      assign w_src_carry[k] = cin;
    end else begin : g_tail
      assign w_src_valid[k] = r_valid[k-1];
      assign w_src_a[k]     = r_a[k-1];
      assign w_src_b[k]     = r_b[k-1];
      assign w_src_sum[k]   = r_sum[k-1];
      assign w_src_carry[k] = r_carry[k-1];
    end

    assign w_c[0] = w_src_carry[k];
    for (genvar j = 0; j < CHUNK; j++) begin : g_bit
      fa_cell u_fa (
        .a    (w_src_a[k][k*CHUNK+j]),
        .b    (w_src_b[k][k*CHUNK+j]),
        .cin  (w_c[j]),
        .sum  (w_s[j]),
        .carry(w_c[j+1])
      );
    end

    // Bits of this chunk are still zero in the travelling sum, so OR merges them in.
    assign w_sum_next[k]   = w_src_sum[k] | (WIDTH'(w_s) << (k * CHUNK));
    assign w_carry_next[k] = w_c[CHUNK];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
        r_carry[k] <= 1'b0;
      end
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_src_valid[k];
        r_a[k]     <= w_src_a[k];
        r_b[k]     <= w_src_b[k];
        r_sum[k]   <= w_sum_next[k];
        r_carry[k] <= w_carry_next[k];
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign cout      = r_carry[LAST];
  assign ovf       = (r_a[LAST][MSB] == r_b[LAST][MSB]) && (r_sum[LAST][MSB] != r_a[LAST][MSB]);

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed and randomized checks of pipe_adder at STAGES 4, 1 and 16
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, cout, ovf;

  logic        x_in_valid [2];
  logic        x_in_ready [2];
  logic        x_out_valid[2];
  logic        x_out_ready[2];
  logic [15:0] x_a        [2];
  logic [15:0] x_b        [2];
  logic [15:0] x_sum      [2];
  logic        x_cin      [2];
  logic        x_cout     [2];
  logic        x_ovf      [2];

  int checks   = 0;
  int failures = 0;

  logic [15:0] ov_a   [6] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234, 16'h7FFF, 16'h8000};
  logic [15:0] ov_b   [6] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h4321, 16'h0000, 16'hFFFF};
  logic        ov_c   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0] ov_sum [6] = '{16'h8000, 16'h0000, 16'hFFFE, 16'h5556, 16'h8000, 16'h7FFF};
  logic        ov_co  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        ov_ov  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  pipe_adder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_adder #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(x_in_valid[0]), .in_ready(x_in_ready[0]), .a(x_a[0]),
    .b(x_b[0]), .cin(x_cin[0]), .out_valid(x_out_valid[0]), .out_ready(x_out_ready[0]),
    .sum(x_sum[0]), .cout(x_cout[0]), .ovf(x_ovf[0])
  );

  pipe_adder #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst(rst), .in_valid(x_in_valid[1]), .in_ready(x_in_ready[1]), .a(x_a[1]),
    .b(x_b[1]), .cin(x_cin[1]), .out_valid(x_out_valid[1]), .out_ready(x_out_ready[1]),
    .sum(x_sum[1]), .cout(x_cout[1]), .ovf(x_ovf[1])
  );

  // Sends one beat into an idle main pipeline and waits (bounded) for its result.
  task automatic run_beat(input logic [15:0] pa, input logic [15:0] pb, input logic pc,
                          output logic [15:0] rs, output logic rc, output logic ro, output int lat);
    a = pa; b = pb; cin = pc; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({out_valid, in_ready, sum, cout, ovf} !== {1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got valid=%b ready=%b sum=%h cout=%b ovf=%b exp 0 1 0000 0 0",
               out_valid, in_ready, sum, cout, ovf);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (x_out_valid[i] !== 1'b0 || x_sum[i] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_state_alt%0d got valid=%b sum=%h exp 0 0000", i, x_out_valid[i], x_sum[i]);
      end
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_carry();
    logic [15:0] s; logic c, o; int lat;
    run_beat(16'hFFFF, 16'h0001, 1'b0, s, c, o, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL carry_latency got=%0d exp=4", lat); end
    checks++;
    if ({s, c, o} !== {16'h0000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL carry_result got sum=%h cout=%b ovf=%b exp 0000 1 0", s, c, o);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] s; logic c, o; int lat;
    for (int i = 0; i < 6; i++) begin
      run_beat(ov_a[i], ov_b[i], ov_c[i], s, c, o, lat);
      checks++;
      if ({s, c, o} !== {ov_sum[i], ov_co[i], ov_ov[i]} || lat !== 4) begin
        failures++;
        $display("FAIL overflow_vec%0d got sum=%h cout=%b ovf=%b lat=%0d exp %h %b %b 4",
                 i, s, c, o, lat, ov_sum[i], ov_co[i], ov_ov[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got[$];
    @(posedge clk); #1;
    out_ready = 1'b0; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(2 * i + 1); b = 16'(2 * i + 2); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, 16'd4}) begin
        failures++;
        $display("FAIL stall_cycle%0d got valid=%b ready=%b sum=%0d exp 1 0 4", i, out_valid, in_ready, sum);
      end
    end
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) got.push_back(sum);
      @(posedge clk); #1;
    end
    checks++;
    if (got.size() != 3 || got[0] !== 16'd4 || got[1] !== 16'd8 || got[2] !== 16'd12) begin
      failures++;
      $display("FAIL back_to_back_order got count=%0d first=%0d exp 3 beats 4 8 12",
               got.size(), (got.size() > 0) ? got[0] : 16'hFFFF);
    end
  endtask

  task automatic test_reset_flight();
    logic [15:0] s; logic c, o; int lat; int stale;
    @(posedge clk); #1;
    out_ready = 1'b1; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0010 << i; b = 16'h0020 << i; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, sum} !== {1'b1, 16'h0030}) begin
      failures++;
      $display("FAIL flight_head got valid=%b sum=%h exp 1 0030", out_valid, sum);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, sum, cout} !== {1'b0, 1'b1, 16'h0000, 1'b0}) begin
      failures++;
      $display("FAIL async_clear got valid=%b ready=%b sum=%h cout=%b exp 0 1 0000 0",
               out_valid, in_ready, sum, cout);
    end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin failures++; $display("FAIL no_stale got=%0d exp=0", stale); end
    run_beat(16'h0100, 16'h0011, 1'b0, s, c, o, lat);
    checks++;
    if (lat !== 4 || s !== 16'h0111) begin
      failures++;
      $display("FAIL post_reset_beat got lat=%0d sum=%h exp 4 0111", lat, s);
    end
  endtask

  task automatic test_random(input int idx);
    int stg, lat, accepted, cyc;
    logic [17:0] q[$];
    logic [17:0] exp;
    logic [16:0] full;
    stg = (idx == 0) ? 1 : 16;
    x_a[idx] = 16'h00AB; x_b[idx] = 16'h0F0F; x_cin[idx] = 1'b1;
    x_in_valid[idx] = 1'b1; x_out_ready[idx] = 1'b1;
    @(posedge clk); #1;
    x_in_valid[idx] = 1'b0;
    lat = 1;
    while (x_out_valid[idx] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != stg || x_sum[idx] !== 16'h0FBB) begin
      failures++;
      $display("FAIL rand%0d_latency got lat=%0d sum=%h exp %0d 0fbb", stg, lat, x_sum[idx], stg);
    end
    @(posedge clk); #1;
    accepted = 0; cyc = 0;
    while ((accepted < 1000 || q.size() > 0) && cyc < 20000) begin
      x_in_valid[idx]  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      x_a[idx]         = 16'($urandom);
      x_b[idx]         = 16'($urandom);
      x_cin[idx]       = 1'($urandom);
      x_out_ready[idx] = ($urandom_range(0, 3) != 0);
      #1;
      if (x_out_valid[idx] === 1'b1 && x_out_ready[idx] === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand%0d_extra got sum=%h exp no beat", stg, x_sum[idx]);
        end else begin
          exp = q.pop_front();
          if ({x_sum[idx], x_cout[idx], x_ovf[idx]} !== exp) begin
            failures++;
            $display("FAIL rand%0d_result got sum=%h cout=%b ovf=%b exp %h %b %b", stg,
                     x_sum[idx], x_cout[idx], x_ovf[idx], exp[17:2], exp[1], exp[0]);
          end
        end
      end
      if (x_in_valid[idx] === 1'b1 && x_in_ready[idx] === 1'b1) begin
        full = 17'(x_a[idx]) + 17'(x_b[idx]) + 17'(x_cin[idx]);
        q.push_back({full[15:0], full[16],
                     (x_a[idx][15] == x_b[idx][15]) && (full[15] != x_a[idx][15])});
        accepted++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    x_in_valid[idx] = 1'b0; x_out_ready[idx] = 1'b1;
    checks++;
    if (accepted != 1000 || q.size() != 0) begin
      failures++;
      $display("FAIL rand%0d_drain got accepted=%0d pending=%0d exp 1000 0", stg, accepted, q.size());
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x_in_valid[i] = 1'b0; x_out_ready[i] = 1'b1;
      x_a[i] = '0; x_b[i] = '0; x_cin[i] = 1'b0;
    end
    test_reset();
    test_carry();
    test_overflow();
    test_back_to_back();
    test_reset_flight();
    test_random(0);
    test_random(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
